// File: rtl/rgmii_speed_adapter.sv
// RGMII <-> GMII adapter for 10/100/1000: byte passthrough at 1000M, nibble assembly/split at 10/100M.
// Optional in-band PHY status decoding is built when RGMII_INBAND_STATUS_EN is defined.
module rgmii_speed_adapter #(
  parameter int unsigned RX_PIPE_STAGES = 1,
  parameter logic [1:0]  INIT_SPEED     = 2'b10
) (
  input  logic       rgmii_clk,
  input  logic       rst_n,
  input  logic [1:0] speed_sel,
  input  logic       rx_ctl_r,
  input  logic       rx_ctl_f,
  input  logic [3:0] rxd_r,
  input  logic [3:0] rxd_f,
  output logic       mac_rx_data_valid,
  output logic [7:0] mac_rx_data,
  output logic       mac_rx_error,
  input  logic       mac_tx_data_valid,
  input  logic [7:0] mac_tx_data,
  output logic       mac_tx_ready,
  output logic       tx_ctl_r,
  output logic       tx_ctl_f,
  output logic [3:0] txd_r,
  output logic [3:0] txd_f,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  typedef enum logic [1:0] {RxIdle, RxHi, RxLo, RxGig} rx_state_e;
  typedef enum logic {TxLo, TxHi} tx_state_e;

  logic [1:0] act_speed_q, act_speed_d;
  logic       gig;
  logic       rx_idle, tx_idle;

  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_low_q, rx_low_d;
  logic       rx_low_err_q, rx_low_err_d;
  logic       s0_valid, s0_err;
  logic [7:0] s0_data;

  logic [9:0] pipe_q [RX_PIPE_STAGES];
  logic [9:0] pipe_d [RX_PIPE_STAGES];

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_hi_q, tx_hi_d;
  logic       tx_ctl_q, tx_ctl_d;
  logic [3:0] txd_r_q, txd_r_d;
  logic [3:0] txd_f_q, txd_f_d;
  logic       ready_q, ready_d;
  logic       tx_accept;

  logic       link_up_q, link_up_d;
  logic [1:0] link_speed_q, link_speed_d;
  logic       full_duplex_q, full_duplex_d;

  assign gig = act_speed_q[1];

  // A pending RX nibble or an offered TX byte blocks the speed switch.
  assign rx_idle = (rx_state_q == RxIdle) && !rx_ctl_r;
  assign tx_idle = (tx_state_q == TxLo) && !mac_tx_data_valid;

  always_comb begin
    act_speed_d = act_speed_q;
    if (rx_idle && tx_idle) begin
      act_speed_d = (speed_sel == 2'b11) ? 2'b10 : speed_sel;
    end
  end

  // RX: stage 0 is combinational, followed by RX_PIPE_STAGES output registers.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_low_d     = rx_low_q;
    rx_low_err_d = rx_low_err_q;
    s0_valid     = 1'b0;
    s0_err       = 1'b0;
    s0_data      = 8'h00;
    if (gig) begin
      s0_valid   = rx_ctl_r;
      s0_data    = rx_ctl_r ? {rxd_f, rxd_r} : 8'h00;
      s0_err     = rx_ctl_r & ~rx_ctl_f;
      rx_state_d = rx_ctl_r ? RxGig : RxIdle;
    end else begin
      unique case (rx_state_q)
        RxIdle, RxLo, RxGig: begin
          if (rx_ctl_r) begin
            rx_low_d     = rxd_r;
            rx_low_err_d = ~rx_ctl_f;
            rx_state_d   = RxHi;
          end else begin
            rx_state_d = RxIdle;
          end
        end
        RxHi: begin
          s0_valid = 1'b1;
          if (rx_ctl_r) begin
            s0_data    = {rxd_r, rx_low_q};
            s0_err     = rx_low_err_q | ~rx_ctl_f;
            rx_state_d = RxLo;
          end else begin
            s0_data    = {4'h0, rx_low_q};
            s0_err     = 1'b1;
            rx_state_d = RxIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    pipe_d[0] = {s0_valid, s0_err, s0_data};
    for (int unsigned i = 1; i < RX_PIPE_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign mac_rx_data_valid = pipe_q[RX_PIPE_STAGES-1][9];
  assign mac_rx_error      = pipe_q[RX_PIPE_STAGES-1][8];
  assign mac_rx_data       = pipe_q[RX_PIPE_STAGES-1][7:0];

  // TX: all ODDR-facing outputs are registered, so every accept shows up one cycle later.
  assign tx_accept = mac_tx_data_valid && ready_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_hi_d    = tx_hi_q;
    tx_ctl_d   = 1'b0;
    txd_r_d    = 4'h0;
    txd_f_d    = 4'h0;
    if (gig) begin
      tx_state_d = TxLo;
      if (tx_accept) begin
        tx_ctl_d = 1'b1;
        txd_r_d  = mac_tx_data[3:0];
        txd_f_d  = mac_tx_data[7:4];
      end
    end else begin
      unique case (tx_state_q)
        TxLo: begin
          if (tx_accept) begin
            tx_ctl_d   = 1'b1;
            txd_r_d    = mac_tx_data[3:0];
            txd_f_d    = mac_tx_data[3:0];
            tx_hi_d    = mac_tx_data[7:4];
            tx_state_d = TxHi;
          end
        end
        TxHi: begin
          tx_ctl_d   = 1'b1;
          txd_r_d    = tx_hi_q;
          txd_f_d    = tx_hi_q;
          tx_state_d = TxLo;
        end
      endcase
    end
    ready_d = act_speed_d[1] | (tx_state_d == TxLo);
  end

  assign mac_tx_ready = ready_q;
  assign tx_ctl_r     = tx_ctl_q;
  assign tx_ctl_f     = tx_ctl_q;
  assign txd_r        = txd_r_q;
  assign txd_f        = txd_f_q;

`ifdef RGMII_INBAND_STATUS_EN
  logic [3:0] stat_prev_q, stat_prev_d;
  logic       stat_prev_vld_q, stat_prev_vld_d;

  // Status only counts when two back-to-back idle samples agree.
  always_comb begin
    stat_prev_d     = stat_prev_q;
    stat_prev_vld_d = 1'b0;
    link_up_d       = link_up_q;
    link_speed_d    = link_speed_q;
    full_duplex_d   = full_duplex_q;
    if (!rx_ctl_r && !rx_ctl_f) begin
      stat_prev_d     = rxd_r;
      stat_prev_vld_d = 1'b1;
      if (stat_prev_vld_q && (stat_prev_q == rxd_r)) begin
        link_up_d     = rxd_r[0];
        link_speed_d  = rxd_r[2:1];
        full_duplex_d = rxd_r[3];
      end
    end
  end

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_prev_q     <= 4'h0;
      stat_prev_vld_q <= 1'b0;
    end else begin
      stat_prev_q     <= stat_prev_d;
      stat_prev_vld_q <= stat_prev_vld_d;
    end
  end
`else
  always_comb begin
    link_up_d     = 1'b1;
    link_speed_d  = act_speed_d;
    full_duplex_d = 1'b1;
  end
`endif

  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign full_duplex = full_duplex_q;

  always_ff @(posedge rgmii_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_speed_q   <= INIT_SPEED;
      rx_state_q    <= RxIdle;
      rx_low_q      <= 4'h0;
      rx_low_err_q  <= 1'b0;
      tx_state_q    <= TxLo;
      tx_hi_q       <= 4'h0;
      tx_ctl_q      <= 1'b0;
      txd_r_q       <= 4'h0;
      txd_f_q       <= 4'h0;
      ready_q       <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= 2'b00;
      full_duplex_q <= 1'b0;
      for (int unsigned i = 0; i < RX_PIPE_STAGES; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      act_speed_q   <= act_speed_d;
      rx_state_q    <= rx_state_d;
      rx_low_q      <= rx_low_d;
      rx_low_err_q  <= rx_low_err_d;
      tx_state_q    <= tx_state_d;
      tx_hi_q       <= tx_hi_d;
      tx_ctl_q      <= tx_ctl_d;
      txd_r_q       <= txd_r_d;
      txd_f_q       <= txd_f_d;
      ready_q       <= ready_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      full_duplex_q <= full_duplex_d;
      for (int unsigned i = 0; i < RX_PIPE_STAGES; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rgmii_speed_adapter.sv
// Directed bench for rgmii_speed_adapter: RX/TX at 1000M and 100M, speed switching,
// asynchronous reset mid-frame and, with RGMII_INBAND_STATUS_EN, the status filter.
module tb_rgmii_speed_adapter;

  localparam int PIPE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed_sel;
  logic       rx_ctl_r, rx_ctl_f;
  logic [3:0] rxd_r, rxd_f;
  logic       mac_rx_data_valid;
  logic [7:0] mac_rx_data;
  logic       mac_rx_error;
  logic       mac_tx_data_valid;
  logic [7:0] mac_tx_data;
  logic       mac_tx_ready;
  logic       tx_ctl_r, tx_ctl_f;
  logic [3:0] txd_r, txd_f;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rgmii_speed_adapter #(
    .RX_PIPE_STAGES(PIPE),
    .INIT_SPEED    (2'b10)
  ) dut (
    .rgmii_clk        (clk),
    .rst_n            (rst_n),
    .speed_sel        (speed_sel),
    .rx_ctl_r         (rx_ctl_r),
    .rx_ctl_f         (rx_ctl_f),
    .rxd_r            (rxd_r),
    .rxd_f            (rxd_f),
    .mac_rx_data_valid(mac_rx_data_valid),
    .mac_rx_data      (mac_rx_data),
    .mac_rx_error     (mac_rx_error),
    .mac_tx_data_valid(mac_tx_data_valid),
    .mac_tx_data      (mac_tx_data),
    .mac_tx_ready     (mac_tx_ready),
    .tx_ctl_r         (tx_ctl_r),
    .tx_ctl_f         (tx_ctl_f),
    .txd_r            (txd_r),
    .txd_f            (txd_f),
    .link_up          (link_up),
    .link_speed       (link_speed),
    .full_duplex      (full_duplex)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_idle_in();
    rx_ctl_r = 1'b0;
    rx_ctl_f = 1'b0;
    rxd_r    = 4'h0;
    rxd_f    = 4'h0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_link;
    rst_n             = 1'b0;
    speed_sel         = 2'b10;
    mac_tx_data_valid = 1'b0;
    mac_tx_data       = 8'h00;
    rx_idle_in();
    tick();
    tick();
    total++;
    if ({mac_rx_data_valid, mac_rx_data, mac_rx_error} !== 10'h000)
      $display("FAIL reset_rx got %h want 000", {mac_rx_data_valid, mac_rx_data, mac_rx_error});
    else passed++;
    total++;
    if ({tx_ctl_r, tx_ctl_f, txd_r, txd_f} !== 10'h000)
      $display("FAIL reset_tx got %h want 000", {tx_ctl_r, tx_ctl_f, txd_r, txd_f});
    else passed++;
    total++;
    if ({mac_tx_ready, link_up, link_speed, full_duplex} !== 5'b00000)
      $display("FAIL reset_misc got %b want 00000", {mac_tx_ready, link_up, link_speed, full_duplex});
    else passed++;
    #3 rst_n = 1'b1;
    #1;
    total++;
    if (mac_tx_ready !== 1'b0) $display("FAIL ready_before_edge got %b want 0", mac_tx_ready);
    else passed++;
    tick();
    total++;
    if (mac_tx_ready !== 1'b1) $display("FAIL ready_after_edge got %b want 1", mac_tx_ready);
    else passed++;
`ifdef RGMII_INBAND_STATUS_EN
    exp_link = 4'b0000;
`else
    exp_link = 4'b1101;
`endif
    total++;
    if ({link_up, link_speed, full_duplex} !== exp_link)
      $display("FAIL reset_link got %b want %b", {link_up, link_speed, full_duplex}, exp_link);
    else passed++;
  endtask

  task automatic test_rx_gig();
    logic [7:0] bytes [5] = '{8'h55, 8'h55, 8'hD5, 8'hAA, 8'h12};
    logic       errs  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] got, exp;
    int j;
    for (int t = 0; t < 5 + PIPE + 1; t++) begin
      if (t < 5) begin
        rx_ctl_r = 1'b1;
        rx_ctl_f = ~errs[t];
        rxd_r    = bytes[t][3:0];
        rxd_f    = bytes[t][7:4];
      end else begin
        rx_idle_in();
      end
      tick();
      j   = t - (PIPE - 1);
      exp = (j >= 0 && j < 5) ? {1'b1, bytes[j], errs[j]} : 10'h000;
      got = {mac_rx_data_valid, mac_rx_data, mac_rx_error};
      total++;
      if (got !== exp) $display("FAIL rx_gig t=%0d got %h want %h", t, got, exp);
      else passed++;
    end
  endtask

  task automatic test_tx_gig();
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'(i + 1);
      mac_tx_data_valid = 1'b1;
      mac_tx_data       = b;
      tick();
      total++;
      if ({mac_tx_ready, tx_ctl_r, tx_ctl_f, txd_r, txd_f} !== {3'b111, b[3:0], b[7:4]})
        $display("FAIL tx_gig i=%0d got %h want %h", i,
                 {mac_tx_ready, tx_ctl_r, tx_ctl_f, txd_r, txd_f}, {3'b111, b[3:0], b[7:4]});
      else passed++;
    end
    mac_tx_data_valid = 1'b0;
    mac_tx_data       = 8'h00;
    tick();
    total++;
    if ({tx_ctl_r, tx_ctl_f, txd_r, txd_f} !== 10'h000)
      $display("FAIL tx_gig_idle got %h want 000", {tx_ctl_r, tx_ctl_f, txd_r, txd_f});
    else passed++;
  endtask

  task automatic test_speed_change();
    speed_sel = 2'b01;
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin
        rx_ctl_r = 1'b1;
        rx_ctl_f = 1'b1;
        rxd_r    = 4'h5;
        rxd_f    = 4'h5;
      end else begin
        rx_idle_in();
      end
      tick();
`ifndef RGMII_INBAND_STATUS_EN
      total++;
      if (link_speed !== ((t < 4) ? 2'b10 : 2'b01))
        $display("FAIL speed_change t=%0d got %b want %b", t, link_speed,
                 (t < 4) ? 2'b10 : 2'b01);
      else passed++;
`endif
    end
    tick();
    tick();
  endtask

  task automatic test_rx_100();
    logic       ctl [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] nib [8] = '{4'h5, 4'h5, 4'hD, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0};
    logic [9:0] s0  [8] = '{10'h000, {1'b1, 8'h55, 1'b0}, 10'h000, {1'b1, 8'h5D, 1'b0},
                            10'h000, {1'b1, 8'h0A, 1'b1}, 10'h000, 10'h000};
    logic [9:0] got, exp;
    int j;
    for (int t = 0; t < 9; t++) begin
      if (t < 8) begin
        rx_ctl_r = ctl[t];
        rx_ctl_f = ctl[t];
        rxd_r    = nib[t];
        rxd_f    = nib[t];
      end else begin
        rx_idle_in();
      end
      tick();
      j   = t - (PIPE - 1);
      exp = (j >= 0) ? s0[j] : 10'h000;
      got = {mac_rx_data_valid, mac_rx_data, mac_rx_error};
      total++;
      if (got !== exp) $display("FAIL rx_100 t=%0d got %h want %h", t, got, exp);
      else passed++;
    end
  endtask

  task automatic test_tx_100();
    logic       rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] nib [4] = '{4'hC, 4'h3, 4'hC, 4'h3};
    int accepted = 0;
    mac_tx_data_valid = 1'b1;
    mac_tx_data       = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mac_tx_ready !== rdy[i]) $display("FAIL tx_100_ready i=%0d got %b want %b", i,
                                            mac_tx_ready, rdy[i]);
      else passed++;
      if (mac_tx_ready) accepted++;
      tick();
      total++;
      if ({tx_ctl_r, tx_ctl_f, txd_r, txd_f} !== {2'b11, nib[i], nib[i]})
        $display("FAIL tx_100_out i=%0d got %h want %h", i, {tx_ctl_r, tx_ctl_f, txd_r, txd_f},
                 {2'b11, nib[i], nib[i]});
      else passed++;
    end
    mac_tx_data_valid = 1'b0;
    mac_tx_data       = 8'h00;
    tick();
    total++;
    if ({tx_ctl_r, tx_ctl_f, txd_r, txd_f} !== 10'h000)
      $display("FAIL tx_100_idle got %h want 000", {tx_ctl_r, tx_ctl_f, txd_r, txd_f});
    else passed++;
    total++;
    if (accepted !== 2) $display("FAIL tx_100_accepts got %0d want 2", accepted);
    else passed++;
  endtask

  task automatic test_reset_mid_tx();
    mac_tx_data_valid = 1'b1;
    mac_tx_data       = 8'hA5;
    tick();
    total++;
    if ({tx_ctl_r, txd_r} !== 5'h15) $display("FAIL mid_tx_pre got %h want 15", {tx_ctl_r, txd_r});
    else passed++;
    #2 rst_n = 1'b0;
    mac_tx_data_valid = 1'b0;
    mac_tx_data       = 8'h00;
    speed_sel         = 2'b10;
    #1;
    total++;
    if ({tx_ctl_r, tx_ctl_f, txd_r, txd_f, mac_tx_ready} !== 11'h000)
      $display("FAIL mid_tx_async got %h want 000", {tx_ctl_r, tx_ctl_f, txd_r, txd_f, mac_tx_ready});
    else passed++;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (mac_tx_ready !== 1'b1) $display("FAIL mid_tx_ready got %b want 1", mac_tx_ready);
    else passed++;
`ifndef RGMII_INBAND_STATUS_EN
    total++;
    if (link_speed !== 2'b10) $display("FAIL mid_tx_init_speed got %b want 10", link_speed);
    else passed++;
`endif
    tick();
    total++;
    if ({tx_ctl_r, txd_r, mac_rx_data_valid} !== 6'h00)
      $display("FAIL mid_tx_quiet got %h want 00", {tx_ctl_r, txd_r, mac_rx_data_valid});
    else passed++;
  endtask

`ifdef RGMII_INBAND_STATUS_EN
  task automatic test_status();
    logic [3:0] pat [5] = '{4'hD, 4'hD, 4'h0, 4'hD, 4'hD};
    logic [3:0] exp [5] = '{4'b0000, 4'b1101, 4'b1101, 4'b1101, 4'b1101};
    for (int t = 0; t < 5; t++) begin
      rx_ctl_r = 1'b0;
      rx_ctl_f = 1'b0;
      rxd_r    = pat[t];
      rxd_f    = 4'h0;
      tick();
      total++;
      if ({link_up, link_speed, full_duplex} !== exp[t])
        $display("FAIL status t=%0d got %b want %b", t, {link_up, link_speed, full_duplex}, exp[t]);
      else passed++;
    end
    rx_idle_in();
  endtask
`endif

  initial begin
    test_reset();
    test_rx_gig();
    test_tx_gig();
    test_speed_change();
    test_rx_100();
    test_tx_100();
    test_reset_mid_tx();
`ifdef RGMII_INBAND_STATUS_EN
    test_status();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rgmii_speed_adapter.md
# rgmii_speed_adapter

Speed-aware RGMII↔GMII adapter that sits between the DDR I/O primitives (IDDR/ODDR split rise/fall signals) and the MAC. It generalises the fixed gigabit bridge to 10/100/1000 operation: byte passthrough at 1000M, nibble assembly and disassembly at 10/100M with a TX ready handshake, and optional in-band PHY status decoding. The block contains logic only; the I/O primitives and clocking stay outside.

## Interface
- RX_PIPE_STAGES, 1, output register stages on the RX byte path (1–3).
- INIT_SPEED, 2'b10, active speed after reset (00=10M, 01=100M, 10=1000M).

- rgmii_clk  in  1  RX-recovered RGMII clock; 125/25/2.5 MHz by speed.
- rst_n  in  1  Reset, asynchronous, active-low.
- speed_sel  in  2  Requested speed: 00=10M, 01=100M, 10=1000M; 11 is treated as 1000M.
- rx_ctl_r, rx_ctl_f  in  1  IDDR rise/fall samples of RX_CTL. Rise carries valid; fall carries valid^error.
- rxd_r, rxd_f  in  4  IDDR rise/fall RXD nibbles.
- mac_rx_data_valid  out  1  RX byte strobe.
- mac_rx_data  out  8  RX byte.
- mac_rx_error  out  1  RX error, qualified with valid.
- mac_tx_data_valid  in  1  TX byte offered.
- mac_tx_data  in  8  TX byte.
- mac_tx_ready  out  1  A byte is accepted when valid && ready.
- tx_ctl_r, tx_ctl_f  out  1  ODDR rise/fall TX_CTL.
- txd_r, txd_f  out  4  ODDR rise/fall TXD.
- link_up  out  1  Link status.
- link_speed  out  2  Speed reported by the PHY.
- full_duplex  out  1  Duplex reported by the PHY.

## Operation
- **Active speed.** `act_speed` resets to INIT_SPEED. `speed_sel` is loaded into it only when both RX and TX FSMs are idle. A change requested mid-frame is deferred.
- **RX at 1000M.**
  - byte = {rxd_f, rxd_r}
  - valid = rx_ctl_r
  - error = rx_ctl_r ^ rx_ctl_f
- **RX at 10/100M.** Only rising samples are used. FSM states:
  - RX_IDLE: on rx_ctl_r=1, store rxd_r as the low nibble and go to RX_HI.
  - RX_HI with rx_ctl_r=1: emit {rxd_r, low} with error = OR of both nibble errors, then go to RX_LO.
  - RX_LO: on rx_ctl_r=1, store the low nibble and go to RX_HI; on rx_ctl_r=0, go to RX_IDLE.
  - Odd nibble count (rx_ctl_r drops while in RX_HI): emit {4'h0, low} with mac_rx_error=1, then go to RX_IDLE.
- **TX at 1000M.**
  - mac_tx_ready=1
  - txd_r = data[3:0], txd_f = data[7:4]
  - tx_ctl_r = tx_ctl_f = valid; the error bit is never set.
- **TX at 10/100M.** FSM states:
  - TX_LO: ready=1. On accept, drive the low nibble on both txd_r and txd_f, then go to TX_HI.
  - TX_HI: ready=0. Drive the high nibble on both, then return to TX_LO.
  - tx_ctl_r = tx_ctl_f = 1 on both nibbles.
  - Idle (no accept in TX_LO): ctl=0, txd=0.
- **In-band status.** Sampled when rx_ctl_r=0 and rx_ctl_f=0.
  - rxd_r[0] = link, rxd_r[2:1] = speed, rxd_r[3] = duplex.
  - Outputs update only after two consecutive identical idle samples.

## Timing
- **Reset values.**
  - All mac_rx_* = 0, tx_ctl_* = 0, txd_* = 0.
  - mac_tx_ready = 0; it rises on the first rgmii_clk edge after rst_n deasserts.
  - link_up = 0, link_speed = 00, full_duplex = 0.
  - Both FSMs in IDLE/TX_LO.
- **Reset mid-frame.** Outputs return to reset values asynchronously. Partial nibbles are discarded with no error byte.
- **RX latency.** 1000M: RX_PIPE_STAGES cycles from the IDDR sample. 10/100M: RX_PIPE_STAGES cycles after the high-nibble sample.
- **RX spacing at 10/100M.** mac_rx_data_valid is never asserted on consecutive cycles.
- **TX latency.** Accept at cycle k → first output at k+1 in all modes.
  - 10/100M: high nibble at k+2; ready low at k+1, high at k+2.
  - Sustained 10/100M throughput is one byte per two cycles.
- **Status latency.** link_* update 2 cycles after a new stable idle pattern first appears.
- **Speed change latency.** A speed_sel change takes effect on the cycle after both FSMs are idle.

## Configuration
- Macro: RGMII_INBAND_STATUS_EN.
- **Defined:** the in-band status decoder and filter are present, as described in Operation.
- **Undefined:** no decoder logic is built.
  - link_up = 1 after reset.
  - link_speed = act_speed.
  - full_duplex = 1.

## Test plan
- **1000M RX.** Frame 55,55,D5,AA with {rxd_f, rxd_r} and ctl_r=ctl_f=1 → mac_rx_data = same bytes, valid=1, error=0, delayed RX_PIPE_STAGES cycles. One byte with ctl_f=0 → error=1 on that byte only.
- **100M RX.** Nibbles 5,5,D,5 on rxd_r with ctl_r=1 → bytes 55, 5D, each valid for one cycle with a gap between. Third, odd nibble A then ctl_r=0 → byte 0A with error=1.
- **100M TX.** mac_tx_data=3C held valid for 4 cycles → txd_r=txd_f sequence C,3,C,3 with ctl=1; ready pattern 1,0,1,0; two bytes accepted.
- **1000M TX.** Bytes 01..04 back-to-back → ready=1 throughout; txd_r/txd_f = 1/0, 2/0, 3/0, 4/0, one cycle after each accept.
- **Speed change.** speed_sel switches 10→01 mid-frame → act_speed holds until both FSMs are idle, then changes. Assert rst_n=0 mid-TX → tx_ctl and txd go to 0 immediately.
- **In-band status (with RGMII_INBAND_STATUS_EN).** Idle rxd_r=4'hD for 2 cycles → link_up=1, link_speed=10, full_duplex=1. A single-cycle glitch to 4'h0 → no change.
